// File: rtl/ttt_pkg.sv
// ttt_pkg: cell/who encodings, line and priority tables, FSM states for ttt_computer_player
package ttt_pkg;
  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_PLAYER = 2'b01;
  localparam logic [1:0] CELL_COMP = 2'b10;
  localparam logic [1:0] WHO_NONE = 2'b00;
  localparam logic [1:0] WHO_PLAYER = 2'b01;
  localparam logic [1:0] WHO_COMP = 2'b10;
  localparam logic [1:0] WHO_DRAW = 2'b11;
  localparam logic [3:0] LINE_TABLE [8][3] = '{
    '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
  };
  localparam logic [3:0] PRIO_TABLE [9] = '{4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7};
  typedef enum logic [2:0] {WAIT, SNAP, WIN, BLOCK, FALL, ISSUE, ACK, DONE} state_t;
endpackage

// File: rtl/ttt_line_eval.sv
// ttt_line_eval: flags a line holding two target marks and one empty cell, returns the empty slot
module ttt_line_eval
  import ttt_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] c,
  input  logic [1:0] mark,
  output logic       hit,
  output logic [1:0] slot
);
  logic h0, h1, h2;
  assign h0 = a == CELL_EMPTY && b == mark && c == mark;
  assign h1 = a == mark && b == CELL_EMPTY && c == mark;
  assign h2 = a == mark && b == mark && c == CELL_EMPTY;
  assign hit = h0 | h1 | h2;
  assign slot = h0 ? 2'd0 : h1 ? 2'd1 : 2'd2;
endmodule

// File: rtl/ttt_computer_player.sv
// ttt_computer_player: auto move generator (win, block when TTT_AI_BLOCK_EN, then priority cell)
module ttt_computer_player
  import ttt_pkg::*;
#(
  parameter int PC_PULSE = 2,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] pos1,
  input  logic [1:0] pos2,
  input  logic [1:0] pos3,
  input  logic [1:0] pos4,
  input  logic [1:0] pos5,
  input  logic [1:0] pos6,
  input  logic [1:0] pos7,
  input  logic [1:0] pos8,
  input  logic [1:0] pos9,
  input  logic [1:0] who,
  output logic [3:0] computer_position,
  output logic       pc,
  output logic       busy,
  output logic       error
);
  state_t state;
  logic [1:0] live [9];
  logic [1:0] snap [9];
  logic [1:0] mark, slot;
  logic [3:0] idx, n_player, n_comp, hit_cell;
  logic [7:0] cnt;
  logic turn, any_empty, all_empty, hit;
`ifdef TTT_AI_BLOCK_EN
  localparam state_t AFTER_WIN = BLOCK;
  assign mark = state == BLOCK ? CELL_PLAYER : CELL_COMP;
`else
  localparam state_t AFTER_WIN = FALL;
  assign mark = CELL_COMP;
`endif
  assign live = '{pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9};
  always_comb begin
    n_player = '0;
    n_comp = '0;
    any_empty = 1'b0;
    all_empty = 1'b1;
    for (int i = 0; i < 9; i++) begin
      n_player += 4'(live[i] == CELL_PLAYER);
      n_comp += 4'(live[i] == CELL_COMP);
      any_empty |= live[i] == CELL_EMPTY;
      all_empty &= live[i] == CELL_EMPTY;
    end
    turn = enable && who == WHO_NONE && n_player == n_comp + 4'd1 && any_empty;
  end
  ttt_line_eval u_eval (
    .a   (snap[LINE_TABLE[idx[2:0]][0]]),
    .b   (snap[LINE_TABLE[idx[2:0]][1]]),
    .c   (snap[LINE_TABLE[idx[2:0]][2]]),
    .mark(mark),
    .hit (hit),
    .slot(slot)
  );
  assign hit_cell = LINE_TABLE[idx[2:0]][slot];
  assign pc = state == ISSUE;
  assign busy = !(state == WAIT || state == DONE);
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= WAIT;
      computer_position <= '0;
      error <= 1'b0;
      cnt <= '0;
      idx <= '0;
      snap <= '{default: CELL_EMPTY};
    end else begin
      case (state)
        WAIT: if (who != WHO_NONE) state <= DONE;
          else if (turn) begin
            state <= SNAP;
            snap <= live;
          end
        SNAP: begin
          state <= WIN;
          idx <= '0;
        end
        WIN, BLOCK: if (hit) begin
            computer_position <= hit_cell;
            state <= ISSUE;
            cnt <= '0;
          end else if (idx == 4'd7) begin
            state <= state == WIN ? AFTER_WIN : FALL;
            idx <= '0;
          end else idx <= idx + 4'd1;
        FALL: if (snap[PRIO_TABLE[idx]] == CELL_EMPTY) begin
            computer_position <= PRIO_TABLE[idx];
            state <= ISSUE;
            cnt <= '0;
          end else idx <= idx + 4'd1;
        ISSUE: if (cnt == 8'(PC_PULSE - 1)) begin
            state <= ACK;
            cnt <= '0;
          end else cnt <= cnt + 8'd1;
        ACK: if (live[computer_position] == CELL_COMP) state <= WAIT;
          else if (who != WHO_NONE) state <= DONE;
          else if (cnt == 8'(ACK_TIMEOUT - 1)) begin
            error <= 1'b1;
            state <= WAIT;
          end else cnt <= cnt + 8'd1;
        DONE: if (all_empty) state <= WAIT;
        default: state <= WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_ttt_computer_player.sv
// tb_ttt_computer_player: directed checks of move choice, pc timing, timeout, reset and game-over
module tb_ttt_computer_player;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b1;
  logic [1:0] b [9];
  logic [1:0] who = 2'b00;
  logic [3:0] cp;
  logic pc, busy, error;
  int vectors = 0;
  int errors = 0;
  int n, pcs;
`ifdef TTT_AI_BLOCK_EN
  localparam int BLK_LAT = 12, BLK_POS = 3, FALL_LAT = 20;
`else
  localparam int BLK_LAT = 13, BLK_POS = 2, FALL_LAT = 12;
`endif
  ttt_computer_player dut (
    .clock(clk), .reset(reset), .enable(enable),
    .pos1(b[0]), .pos2(b[1]), .pos3(b[2]), .pos4(b[3]), .pos5(b[4]),
    .pos6(b[5]), .pos7(b[6]), .pos8(b[7]), .pos9(b[8]),
    .who(who), .computer_position(cp), .pc(pc), .busy(busy), .error(error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic load(input logic [8:0] o, input logic [8:0] x);
    for (int i = 0; i < 9; i++) b[i] = o[i] ? 2'b10 : x[i] ? 2'b01 : 2'b00;
  endtask
  task automatic wait_pc(output int k);
    k = 0;
    do begin
      @(posedge clk);
      #1;
      k++;
    end while (!pc && k < 40);
  endtask
  task automatic do_move(input string tag, input int lat, input int p);
    int k;
    wait_pc(k);
    chk({tag, "_lat"}, k, lat);
    chk({tag, "_pos"}, int'(cp), p);
    @(posedge clk);
    #1 chk({tag, "_pc2"}, int'(pc), 1);
    @(posedge clk);
    #1 chk({tag, "_pcoff"}, int'(pc), 0);
    chk({tag, "_ackbusy"}, int'(busy), 1);
    @(negedge clk);
    b[cp] = 2'b10;
    @(posedge clk);
    #1 chk({tag, "_idle"}, int'(busy), 0);
    chk({tag, "_err"}, int'(error), 0);
  endtask
  initial begin
    load(9'd0, 9'd0);
    repeat (2) @(posedge clk);
    #1 chk("init_pc", int'(pc), 0);
    chk("init_busy", int'(busy), 0);
    chk("init_err", int'(error), 0);
    chk("init_pos", int'(cp), 0);
    @(negedge clk);
    reset = 1'b0;
    load(9'b000000011, 9'b100011000);
    do_move("win", 3, 2);
    @(negedge clk);
    load(9'b000000001, 9'b000110000);
    do_move("block", BLK_LAT, BLK_POS);
    @(negedge clk);
    load(9'd0, 9'b000010000);
    do_move("fall", FALL_LAT, 0);
    @(negedge clk);
    load(9'b000000011, 9'b100011000);
    wait_pc(n);
    chk("to_lat", n, 3);
    @(posedge clk);
    @(posedge clk);
    #1 chk("to_pcoff", int'(pc), 0);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!error && n < 40);
    chk("to_cycles", n, 16);
    chk("to_busy", int'(busy), 0);
    @(negedge clk);
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("dis_busy", int'(busy), 0);
    @(negedge clk);
    enable = 1'b1;
    wait_pc(n);
    chk("rst_lat", n, 3);
    @(negedge clk);
    reset = 1'b1;
    load(9'd0, 9'd0);
    @(posedge clk);
    #1 chk("rst_pc", int'(pc), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(error), 0);
    chk("rst_pos", int'(cp), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1 chk("rst_idle", int'(busy), 0);
    @(negedge clk);
    load(9'b000000011, 9'b100011000);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    who = 2'b01;
    wait_pc(n);
    chk("go_lat", n, 1);
    chk("go_pos", int'(cp), 2);
    @(posedge clk);
    #1 chk("go_pc2", int'(pc), 1);
    @(posedge clk);
    #1 chk("go_ack", int'(busy), 1);
    @(posedge clk);
    #1 chk("go_done", int'(busy), 0);
    @(negedge clk);
    who = 2'b00;
    pcs = 0;
    repeat (6) begin
      @(posedge clk);
      #1 pcs += int'(pc) + int'(busy);
    end
    chk("go_hold", pcs, 0);
    @(negedge clk);
    load(9'd0, 9'd0);
    @(posedge clk);
    @(negedge clk);
    load(9'd0, 9'b000010000);
    do_move("post", FALL_LAT, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
